// File: rtl/cpu_pipeline_fwd.sv
// Five-stage in-order core (Fetch, Decode, Execute, Memory, Writeback) with optional
// EX/MEM/WB operand bypass, LDI/JMP and a wait-state handshake on the data bus.
module cpu_pipeline_fwd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int FORWARDING = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  output logic [ADDR_WIDTH-1:0] o_pc,
  input  logic [31:0]           i_instruction,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_rw,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_stall,
  output logic                  o_retire,
  output logic [31:0]           o_debug_ir
);

  localparam logic [2:0] OP_NOP = 3'd0, OP_LDA = 3'd1, OP_STA = 3'd2, OP_ADD = 3'd3,
                         OP_SUB = 3'd4, OP_LDI = 3'd5, OP_JMP = 3'd6;

  function automatic logic reg_ok(input logic [3:0] r);
    return {1'b0, r} < 5'(NUM_REGS);
  endfunction

  // Youngest producer wins; the WB match doubles as register-file write-through.
  function automatic logic [DATA_WIDTH-1:0] pick(input logic ok, input logic mem_hit,
                                                 input logic wb_hit,
                                                 input logic [DATA_WIDTH-1:0] mem_v,
                                                 input logic [DATA_WIDTH-1:0] wb_v,
                                                 input logic [DATA_WIDTH-1:0] rf_v);
    if (!ok) return '0;
    if (mem_hit) return mem_v;
    if (wb_hit) return wb_v;
    return rf_v;
  endfunction

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_ir;
  logic [DATA_WIDTH-1:0] r_regs [16];

  logic [2:0]            r_op_p1, r_op_p2;
  logic                  r_we_p1, r_we_p2, r_we_p3, r_vld_p3;
  logic [3:0]            r_ws_p1, r_ws_p2, r_ws_p3, r_rs1_p1, r_rs2_p1;
  logic [15:0]           r_imm_p1;
  logic [DATA_WIDTH-1:0] r_res_p2, r_res_p3;
  logic [ADDR_WIDTH-1:0] r_addr_p2;

  logic [2:0]            w_op_d;
  logic [3:0]            w_rd_d, w_rs1_d, w_rs2_d;
  logic [15:0]           w_imm_d;
  logic                  w_use1_d, w_use2_d, w_we_d;
  logic                  w_hit_ex, w_hit_mem, w_hazard, w_bus_wait;
  logic [DATA_WIDTH-1:0] w_a_p1, w_b_p1, w_res_p1;

  // Decode stage: unknown opcodes collapse to NOP
  always_comb begin
    w_op_d = OP_NOP;
    if (r_ir[31:24] >= 8'd1 && r_ir[31:24] <= 8'd6) w_op_d = r_ir[26:24];
    w_rd_d   = r_ir[23:20];
    w_rs1_d  = r_ir[19:16];
    w_rs2_d  = r_ir[15:12];
    w_imm_d  = r_ir[15:0];
    w_use1_d = (w_op_d == OP_ADD) || (w_op_d == OP_SUB) || (w_op_d == OP_STA);
    w_use2_d = (w_op_d == OP_ADD) || (w_op_d == OP_SUB);
    w_we_d   = ((w_op_d == OP_LDA) || (w_op_d == OP_ADD) || (w_op_d == OP_SUB) ||
                (w_op_d == OP_LDI)) && reg_ok(w_rd_d);
    w_hit_ex  = r_we_p1 && ((w_use1_d && (w_rs1_d == r_ws_p1)) ||
                            (w_use2_d && (w_rs2_d == r_ws_p1)));
    w_hit_mem = r_we_p2 && ((w_use1_d && (w_rs1_d == r_ws_p2)) ||
                            (w_use2_d && (w_rs2_d == r_ws_p2)));
    if (FORWARDING != 0) w_hazard = w_hit_ex && (r_op_p1 == OP_LDA);
    else                 w_hazard = w_hit_ex || w_hit_mem;
  end

  assign w_bus_wait = ((r_op_p2 == OP_LDA) || (r_op_p2 == OP_STA)) && !i_ready;

  // Execute stage: operands resolved live so a held EX sees later writebacks
  always_comb begin
    w_a_p1 = pick(reg_ok(r_rs1_p1),
                  (FORWARDING != 0) && r_we_p2 && (r_op_p2 != OP_LDA) && (r_ws_p2 == r_rs1_p1),
                  r_we_p3 && (r_ws_p3 == r_rs1_p1), r_res_p2, r_res_p3, r_regs[r_rs1_p1]);
    w_b_p1 = pick(reg_ok(r_rs2_p1),
                  (FORWARDING != 0) && r_we_p2 && (r_op_p2 != OP_LDA) && (r_ws_p2 == r_rs2_p1),
                  r_we_p3 && (r_ws_p3 == r_rs2_p1), r_res_p2, r_res_p3, r_regs[r_rs2_p1]);
    case (r_op_p1)
      OP_ADD:  w_res_p1 = w_a_p1 + w_b_p1;
      OP_SUB:  w_res_p1 = w_a_p1 - w_b_p1;
      OP_LDI:  w_res_p1 = DATA_WIDTH'(r_imm_p1);
      OP_STA:  w_res_p1 = w_a_p1;
      default: w_res_p1 = '0;
    endcase
  end

  // Control path: bus wait freezes everything up to MEM and bubbles WB
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_op_p1  <= OP_NOP;
      r_we_p1  <= 1'b0;
      r_op_p2  <= OP_NOP;
      r_we_p2  <= 1'b0;
      r_we_p3  <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else if (w_bus_wait) begin
      r_we_p3  <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else begin
      r_vld_p3 <= (r_op_p2 != OP_NOP);
      r_we_p3  <= r_we_p2;
      r_op_p2  <= r_op_p1;
      r_we_p2  <= r_we_p1;
      if (w_hazard) begin
        r_op_p1 <= OP_NOP;
        r_we_p1 <= 1'b0;
      end else begin
        r_op_p1 <= w_op_d;
        r_we_p1 <= w_we_d;
        if (w_op_d == OP_JMP) begin
          r_pc <= w_imm_d[ADDR_WIDTH-1:0];
          r_ir <= '0;
        end else begin
          r_pc <= r_pc + ADDR_WIDTH'(4);
          r_ir <= i_instruction;
        end
      end
    end
  end

  // Data path: no reset, qualified by the control bits above
  always_ff @(posedge i_clk) begin
    if (!w_bus_wait) begin
      r_ws_p3   <= r_ws_p2;
      r_res_p3  <= (r_op_p2 == OP_LDA) ? i_data : r_res_p2;
      r_ws_p2   <= r_ws_p1;
      r_res_p2  <= w_res_p1;
      r_addr_p2 <= r_imm_p1[ADDR_WIDTH-1:0];
      if (!w_hazard) begin
        r_ws_p1  <= w_rd_d;
        r_rs1_p1 <= w_rs1_d;
        r_rs2_p1 <= w_rs2_d;
        r_imm_p1 <= w_imm_d;
      end
    end
  end

  // Writeback stage
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if (r_we_p3) begin
      r_regs[r_ws_p3] <= r_res_p3;
    end
  end

  assign o_pc       = r_pc;
  assign o_address  = ((r_op_p2 == OP_LDA) || (r_op_p2 == OP_STA)) ? r_addr_p2 : '0;
  assign o_rw       = (r_op_p2 == OP_STA);
  assign o_data     = (r_op_p2 == OP_STA) ? r_res_p2 : '0;
  assign o_stall    = w_hazard && !w_bus_wait;
  assign o_retire   = r_vld_p3;
  assign o_debug_ir = r_ir;

endmodule
